// File: rtl/crc_pkg.sv
// ---- crc_pkg : shared types and helpers for the streaming CRC engine ----
// ---- rev 1.0 ----
`default_nettype none

package crc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Reverses the low w bits of v; bits above w come back as zero.
  function automatic logic [31:0] rev_bits(input logic [31:0] v, input int w);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < w) r[5'(i)] = v[5'(w - 1 - i)];
    end
    return r;
  endfunction

  function automatic int cnt_width(input int steps);
    return (steps > 1) ? $clog2(steps) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/crc_step.sv
// ---- crc_step : combinational fold of BITS_PER_CYC bits into the CRC register ----
// ---- rev 1.0 ----
`default_nettype none

module crc_step
  import crc_pkg::*;
#(
  parameter int          CRC_W        = 8,
  parameter logic [31:0] POLY         = 32'h31,
  parameter bit          REFIN        = 1'b1,
  parameter int          BITS_PER_CYC = 1
) (
  input  logic [CRC_W-1:0]        acc_in,
  input  logic [BITS_PER_CYC-1:0] bits_in,
  output logic [CRC_W-1:0]        acc_out
);

  localparam logic [CRC_W-1:0] POLY_N = POLY[CRC_W-1:0];
  localparam logic [CRC_W-1:0] POLY_R = CRC_W'(rev_bits(POLY, CRC_W));

  logic [BITS_PER_CYC:0][CRC_W-1:0] chain;

  assign chain[0] = acc_in;

  // Reflected mode eats bits_in LSB first, normal mode MSB first.
  for (genvar i = 0; i < BITS_PER_CYC; i++) begin : g_bit
    logic fb;
    if (REFIN) begin : g_ref
      assign fb         = chain[i][0] ^ bits_in[i];
      assign chain[i+1] = (chain[i] >> 1) ^ (fb ? POLY_R : '0);
    end else begin : g_norm
      assign fb         = chain[i][CRC_W-1] ^ bits_in[BITS_PER_CYC-1-i];
      assign chain[i+1] = (chain[i] << 1) ^ (fb ? POLY_N : '0);
    end
  end

  assign acc_out = chain[BITS_PER_CYC];

endmodule

`default_nettype wire

// File: rtl/crc_engine.sv
// ---- crc_engine : parametrised streaming CRC generator/checker ----
// ---- optional CRC_CHECK_EN adds the crc_ok residue check ---- rev 1.0 ----
`default_nettype none

module crc_engine
  import crc_pkg::*;
#(
  parameter int          CRC_W        = 8,
  parameter logic [31:0] POLY         = 32'h31,
  parameter logic [31:0] INIT         = 32'hFF,
  parameter bit          REFIN        = 1'b1,
  parameter bit          REFOUT       = 1'b1,
  parameter logic [31:0] XOROUT       = 32'h00,
  parameter int          DATA_W       = 8,
  parameter int          BITS_PER_CYC = 1,
  parameter logic [31:0] RESIDUE      = 32'h00
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              crc_valid,
  output logic [CRC_W-1:0]  crc
`ifdef CRC_CHECK_EN
  ,
  output logic              crc_ok
`endif
);

  localparam int               STEPS    = DATA_W / BITS_PER_CYC;
  localparam int               CNT_W    = cnt_width(STEPS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STEPS - 1);
  localparam logic [CRC_W-1:0] INIT_V   = INIT[CRC_W-1:0];

  if (DATA_W % BITS_PER_CYC != 0) begin : g_bad_bpc
    $error("crc_engine: BITS_PER_CYC must divide DATA_W");
  end
  if (CRC_W < 3 || CRC_W > 32) begin : g_bad_width
    $error("crc_engine: CRC_W must be within 3..32");
  end

  state_t                  state;
  logic [CRC_W-1:0]        acc;
  logic [DATA_W-1:0]       data_q;
  logic                    last_q;
  logic [CNT_W-1:0]        cnt;
  logic [BITS_PER_CYC-1:0] chunk;
  logic [DATA_W-1:0]       data_shifted;
  logic [CRC_W-1:0]        acc_next;
  logic [CRC_W-1:0]        fin;

  assign in_ready = (state == IDLE);

  // The word register drains from the end that is consumed first.
  assign chunk        = REFIN ? data_q[BITS_PER_CYC-1:0] : data_q[DATA_W-1 -: BITS_PER_CYC];
  assign data_shifted = REFIN ? (data_q >> BITS_PER_CYC) : (data_q << BITS_PER_CYC);

  assign fin = ((REFOUT != REFIN) ? CRC_W'(rev_bits(32'(acc), CRC_W)) : acc)
               ^ XOROUT[CRC_W-1:0];

  crc_step #(
    .CRC_W        (CRC_W),
    .POLY         (POLY),
    .REFIN        (REFIN),
    .BITS_PER_CYC (BITS_PER_CYC)
  ) u_step (
    .acc_in  (acc),
    .bits_in (chunk),
    .acc_out (acc_next)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      acc       <= INIT_V;
      data_q    <= '0;
      last_q    <= 1'b0;
      cnt       <= '0;
      crc_valid <= 1'b0;
      crc       <= '0;
`ifdef CRC_CHECK_EN
      crc_ok    <= 1'b0;
`endif
    end else begin
      crc_valid <= 1'b0;
      if (clear) begin
        state <= IDLE;
        acc   <= INIT_V;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (in_valid) begin
              data_q <= in_data;
              last_q <= in_last;
              cnt    <= '0;
              state  <= SHIFT;
            end
          end
          SHIFT: begin
            acc    <= acc_next;
            data_q <= data_shifted;
            cnt    <= cnt + CNT_W'(1);
            if (cnt == LAST_CNT) state <= last_q ? DONE : IDLE;
          end
          DONE: begin
            crc       <= fin;
            crc_valid <= 1'b1;
`ifdef CRC_CHECK_EN
            crc_ok    <= (acc == RESIDUE[CRC_W-1:0]);
`endif
            acc       <= INIT_V;
            state     <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

`default_nettype wire
